sram_like_ram: RTL and testbench
================================

# sram_like_ram

Responder end of the core's SRAM-like request/response interface (req/wr/size/wstrb/addr/wdata → addr_ok/data_ok/rdata). It serves one instruction or data port from an internal word-addressed RAM. It accepts up to OUTSTANDING requests, returns responses strictly in order, and inserts fixed or pseudo-random delays on both handshakes. It is the standalone memory model used to bring up and stress the pipeline's request/response logic before the AXI bridge is attached.

## Interface
- AW, 12: RAM word-address bits (2^AW 32-bit words); byte address bits [AW+1:2] are used.
- OUTSTANDING, 2: response-queue depth (1..4).
- ADDR_DELAY, 0: cycles `req` must be held before `addr_ok` (fixed mode).
- DATA_DELAY, 1: cycles from accept to `data_ok`, minimum 1 (fixed mode).
- RAND_EN, 0: 1 selects LFSR-driven delays.
- LFSR_SEED, 16'hACE1: LFSR reset value, must be nonzero.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- req  in  1  request valid; the master holds it until `addr_ok`.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0/1/2 = byte/half/word. Informational only; `wstrb` governs writes.
- wstrb  in  4  write byte enables.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle (req & addr_ok = handshake).
- data_ok  out  1  head response valid this cycle; single-cycle pulse per request.
- rdata  out  32  read data, valid with `data_ok`.

## Operation
- Accept counter `acnt`:
  - Loaded with the address delay when `req` rises, and whenever `req` is low.
  - Decrements each cycle `req` is high and `acnt` ≠ 0.
- `addr_ok` = `req` & (`acnt` == 0) & queue not full. It is combinational from state and `req`.
- Full is judged on the current count. A same-cycle pop does not free a slot for a push.
- Handshake, write: RAM word addr[AW+1:2] is updated on that edge, byte i only where wstrb[i]=1. An entry {wr=1, data=0} is enqueued.
- Handshake, read: the RAM word is read using the pre-edge contents, and {wr=0, data=word} is enqueued.
  - Consequence: a read issued after a write to the same word sees the new data.
  - A read never sees a later write.
- The queue is a circular FIFO of OUTSTANDING entries. Pointers wrap modulo the depth, and the count ranges 0..OUTSTANDING.
- Head counter `dcnt`:
  - Loaded with (data delay − 1) when an entry becomes head, either by a push into an empty queue or by a pop that leaves the queue non-empty.
  - Decrements while ≠ 0.
- `data_ok` = queue non-empty & (`dcnt` == 0).
- `rdata` = head data when `data_ok` is 1, otherwise 0. Pop happens on the same edge.
- Push and pop in the same cycle are allowed: the count is unchanged, and the next head loads `dcnt`.
- Random mode uses a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
  - Address delay = lfsr[1:0] (0..3).
  - Data delay = lfsr[4:2] + 1 (1..8).
  - Each value is sampled at the moment its counter loads.
- Reset (resetn=0 on an edge):
  - Queue is emptied and `acnt` is reloaded.
  - `dcnt` = 0 and LFSR = LFSR_SEED.
  - In-flight requests are dropped with no `data_ok`.
  - RAM contents are preserved.

## Timing
- Reset values: addr_ok=0 (req=0), data_ok=0, rdata=0.
- Fixed mode, ADDR_DELAY=0: `addr_ok` is in the same cycle as `req`.
- Fixed mode, ADDR_DELAY=N: `addr_ok` comes in the Nth cycle after `req` rises.
- Accept at edge t into an empty queue: `data_ok` in cycle t+DATA_DELAY.
- DATA_DELAY=1 with continuous `req`: one accept and one `data_ok` per cycle, sustained.
- Queue full: `addr_ok` is 0 and `req` is held. Acceptance resumes the cycle after a pop.
- `req` dropped before the handshake (protocol violation): no state change, and `acnt` reloads.

## Test plan
- Fixed ADDR_DELAY=0, DATA_DELAY=1: write 0x1234_5678 to 0x100 with wstrb=F, then read 0x100.
  - Required: `addr_ok` in the same cycle each time; `data_ok` one cycle after each accept; rdata=0x1234_5678.
- Byte strobes: preload 0xFFFF_FFFF, write 0xAABB_CCDD with wstrb=0101.
  - Required: a read returns 0xFFBB_FFDD.
- Back-to-back reads of 0x0, 0x4, 0x8, OUTSTANDING=2, DATA_DELAY=3.
  - Required: at most 2 accepted before the first `data_ok`; third `addr_ok` arrives the cycle after the first pop; responses in order.
- Write 0x11 then read the same address, accepted on consecutive cycles.
  - Required: the read returns 0x11.
- Reset mid-flight: assert resetn=0 with 2 reads queued.
  - Required: no `data_ok` afterwards; after release, a read of a previously written word returns the old value, since RAM is kept.
- RAND_EN=1, 1000 random reads and writes checked against a reference array.
  - Required: every read matches; addr-ok latency ∈ [0,3]; `data_ok` latency for a head-at-accept request ∈ [1,8].

Source files
------------

// File: rtl/sram_like_ram.sv
// SRAM-like responder: word RAM behind an in-order response queue with fixed or LFSR-driven
// handshake delays. addr_ok is combinational from state and req; data_ok pulses once per request.
module sram_like_ram #(
  parameter int          AW          = 12,
  parameter int          OUTSTANDING = 2,
  parameter int          ADDR_DELAY  = 0,
  parameter int          DATA_DELAY  = 1,
  parameter int          RAND_EN     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int QD = 1 << PW;
  localparam logic [7:0] FIX_ADLY  = 8'(ADDR_DELAY);
  localparam logic [7:0] FIX_DDLY1 = (DATA_DELAY > 1) ? 8'(DATA_DELAY - 1) : 8'd0;
  localparam logic [7:0] RST_ADLY  = (RAND_EN != 0) ? {6'b0, LFSR_SEED[1:0]} : FIX_ADLY;

  logic [31:0]   r_mem [0:(1<<AW)-1];
  logic [31:0]   r_q_dat [QD];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_acnt;
  logic [7:0]    r_dcnt;
  logic [15:0]   r_lfsr;

  logic [AW-1:0] w_word;
  logic [31:0]   w_rd_word;
  logic [7:0]    w_adly;
  logic [7:0]    w_ddly1;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_new_head;
  logic          w_lfsr_fb;
  logic          w_unused;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_unused  = ^{i_size, i_addr[31:AW+2], i_addr[1:0]};
  assign w_word    = i_addr[AW+1:2];
  assign w_rd_word = r_mem[w_word];
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Delays are taken from the live LFSR at the moment each counter loads.
  assign w_adly  = (RAND_EN != 0) ? {6'b0, r_lfsr[1:0]} : FIX_ADLY;
  assign w_ddly1 = (RAND_EN != 0) ? {5'b0, r_lfsr[4:2]} : FIX_DDLY1;

  assign w_full    = (r_count == CW'(OUTSTANDING));
  assign w_empty   = (r_count == '0);
  assign o_addr_ok = i_req & (r_acnt == 8'd0) & ~w_full;
  assign o_data_ok = ~w_empty & (r_dcnt == 8'd0);
  assign o_rdata   = o_data_ok ? r_q_dat[r_rptr] : 32'd0;
  assign w_push    = i_req & o_addr_ok;
  assign w_pop     = o_data_ok;

  // A new head appears on a push into an empty queue or a pop that leaves entries behind.
  assign w_new_head = (w_push & w_empty) | (w_pop & ((r_count > CW'(1)) | w_push));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_lfsr  <= LFSR_SEED;
      r_acnt  <= RST_ADLY;
      r_dcnt  <= 8'd0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

      if (!i_req) begin
        r_acnt <= w_adly;
      end else if (r_acnt != 8'd0) begin
        r_acnt <= r_acnt - 1'b1;
      end

      if (w_push) begin
        r_wptr <= f_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_new_head) begin
        r_dcnt <= w_ddly1;
      end else if (r_dcnt != 8'd0) begin
        r_dcnt <= r_dcnt - 1'b1;
      end
    end
  end

  // Read data is captured from the pre-edge word; write responses carry zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_dat[r_wptr] <= i_wr ? 32'd0 : w_rd_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && i_wr && i_resetn) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[w_word][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_ram.sv
// Bench for sram_like_ram: four instances with different delay settings share one stimulus bus;
// sel picks which instance sees req and whose outputs are observed.
module tb_sram_like_ram;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  sel;
  logic [3:0]  req_v;
  logic [3:0]  ao;
  logic [3:0]  dok;
  logic [31:0] rdv [4];
  logic        addr_ok_m;
  logic        data_ok_m;
  logic [31:0] rdata_m;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rsp_q[$];
  logic [31:0] rsp_d[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_v = req ? (4'b0001 << sel) : 4'b0000;

  always_comb begin
    addr_ok_m = ao[sel];
    data_ok_m = dok[sel];
    rdata_m   = rdv[sel];
  end

  always @(negedge clk) begin
    if (data_ok_m) begin
      rsp_q.push_back(cyc);
      rsp_d.push_back(rdata_m);
    end
  end

  sram_like_ram #(.AW(12), .OUTSTANDING(2), .ADDR_DELAY(0), .DATA_DELAY(1), .RAND_EN(0)) u_fix (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_v[0]), .i_wr(wr), .i_size(size), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata), .o_addr_ok(ao[0]), .o_data_ok(dok[0]), .o_rdata(rdv[0]));

  sram_like_ram #(.AW(12), .OUTSTANDING(2), .ADDR_DELAY(0), .DATA_DELAY(3), .RAND_EN(0)) u_dly (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_v[1]), .i_wr(wr), .i_size(size), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata), .o_addr_ok(ao[1]), .o_data_ok(dok[1]), .o_rdata(rdv[1]));

  sram_like_ram #(.AW(12), .OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(1), .RAND_EN(1)) u_rnd (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_v[2]), .i_wr(wr), .i_size(size), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata), .o_addr_ok(ao[2]), .o_data_ok(dok[2]), .o_rdata(rdv[2]));

  sram_like_ram #(.AW(12), .OUTSTANDING(1), .ADDR_DELAY(2), .DATA_DELAY(2), .RAND_EN(0)) u_ad2 (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_v[3]), .i_wr(wr), .i_size(size), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata), .o_addr_ok(ao[3]), .o_data_ok(dok[3]), .o_rdata(rdv[3]));

  task automatic flush();
    rsp_q.delete();
    rsp_d.delete();
  endtask

  task automatic go_idle(input int n);
    req = 1'b0; wr = 1'b0; wstrb = 4'h0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds req until the handshake; returns first req cycle and accept cycle.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       output int t_start, output int t_acc, output bit ok);
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d; size = 2'd2;
    ok = 1'b0; t_start = -1; t_acc = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (t_start < 0) t_start = cyc;
      if (addr_ok_m) begin ok = 1'b1; t_acc = cyc; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rsp_q.size() >= n) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 4; k++) begin
        sel = 2'(k);
        @(negedge clk);
        total++; if (addr_ok_m !== 1'b0) begin bad++; $display("FAIL reset_addr_ok dut=%0d ph=%0d got=%b want=0", k, ph, addr_ok_m); end
        total++; if (data_ok_m !== 1'b0) begin bad++; $display("FAIL reset_data_ok dut=%0d ph=%0d got=%b want=0", k, ph, data_ok_m); end
        total++; if (rdata_m !== 32'h0) begin bad++; $display("FAIL reset_rdata dut=%0d ph=%0d got=%h want=0", k, ph, rdata_m); end
        @(posedge clk); #1;
      end
      resetn = 1'b1;
    end
  endtask

  task automatic test_basic();
    int s0, a0, s1, a1; bit ok0, ok1, okw;
    sel = 2'd0; flush();
    issue(1'b1, 4'hF, 32'h100, 32'h1234_5678, s0, a0, ok0);
    go_idle(1);
    issue(1'b0, 4'h0, 32'h100, 32'h0, s1, a1, ok1);
    go_idle(1);
    wait_rsp(2, okw);
    total++; if ((ok0 & ok1 & okw) !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%b want=1", ok0 & ok1 & okw); end
    total++; if (a0 - s0 !== 0) begin bad++; $display("FAIL basic_wr_alat got=%0d want=0", a0 - s0); end
    total++; if (a1 - s1 !== 0) begin bad++; $display("FAIL basic_rd_alat got=%0d want=0", a1 - s1); end
    total++; if (rsp_q[0] !== a0 + 1) begin bad++; $display("FAIL basic_wr_dlat got=%0d want=%0d", rsp_q[0], a0 + 1); end
    total++; if (rsp_q[1] !== a1 + 1) begin bad++; $display("FAIL basic_rd_dlat got=%0d want=%0d", rsp_q[1], a1 + 1); end
    total++; if (rsp_d[0] !== 32'h0) begin bad++; $display("FAIL basic_wr_rdata got=%h want=0", rsp_d[0]); end
    total++; if (rsp_d[1] !== 32'h1234_5678) begin bad++; $display("FAIL basic_rd_data got=%h want=12345678", rsp_d[1]); end
  endtask

  task automatic test_strobe();
    int s[3], a[3]; bit ok[3]; bit okw;
    sel = 2'd0; flush();
    issue(1'b1, 4'hF, 32'h200, 32'hFFFF_FFFF, s[0], a[0], ok[0]);
    issue(1'b1, 4'b0101, 32'h200, 32'hAABB_CCDD, s[1], a[1], ok[1]);
    issue(1'b0, 4'h0, 32'h200, 32'h0, s[2], a[2], ok[2]);
    go_idle(1);
    wait_rsp(3, okw);
    total++; if ((ok[0] & ok[1] & ok[2] & okw) !== 1'b1) begin bad++; $display("FAIL strobe_timeout got=0 want=1"); end
    total++; if (a[1] !== a[0] + 1) begin bad++; $display("FAIL strobe_sustain1 got=%0d want=%0d", a[1], a[0] + 1); end
    total++; if (a[2] !== a[1] + 1) begin bad++; $display("FAIL strobe_sustain2 got=%0d want=%0d", a[2], a[1] + 1); end
    total++; if (rsp_q[2] !== a[2] + 1) begin bad++; $display("FAIL strobe_dlat got=%0d want=%0d", rsp_q[2], a[2] + 1); end
    total++; if (rsp_d[2] !== 32'hFFBB_FFDD) begin bad++; $display("FAIL strobe_data got=%h want=ffbbffdd", rsp_d[2]); end
  endtask

  task automatic test_raw();
    int s0, a0, s1, a1; bit ok0, ok1, okw;
    sel = 2'd0; flush();
    issue(1'b1, 4'hF, 32'h300, 32'h11, s0, a0, ok0);
    issue(1'b0, 4'h0, 32'h300, 32'h0, s1, a1, ok1);
    go_idle(1);
    wait_rsp(2, okw);
    total++; if ((ok0 & ok1 & okw) !== 1'b1) begin bad++; $display("FAIL raw_timeout got=0 want=1"); end
    total++; if (a1 !== a0 + 1) begin bad++; $display("FAIL raw_consecutive got=%0d want=%0d", a1, a0 + 1); end
    total++; if (rsp_d[1] !== 32'h11) begin bad++; $display("FAIL raw_data got=%h want=11", rsp_d[1]); end
  endtask

  task automatic test_back_to_back();
    int s[3], a[3]; bit ok[6]; bit okw1, okw2; logic [31:0] v[3];
    sel = 2'd1; flush();
    v[0] = 32'hA0A0_0001; v[1] = 32'hA0A0_0002; v[2] = 32'hA0A0_0003;
    for (int i = 0; i < 3; i++) issue(1'b1, 4'hF, 32'(4 * i), v[i], s[i], a[i], ok[i]);
    go_idle(1);
    wait_rsp(3, okw1);
    flush();
    for (int i = 0; i < 3; i++) issue(1'b0, 4'h0, 32'(4 * i), 32'h0, s[i], a[i], ok[3 + i]);
    go_idle(1);
    wait_rsp(3, okw2);
    total++; if ((ok[0] & ok[1] & ok[2] & ok[3] & ok[4] & ok[5] & okw1 & okw2) !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=0 want=1"); end
    total++; if (a[1] !== a[0] + 1) begin bad++; $display("FAIL b2b_second_accept got=%0d want=%0d", a[1], a[0] + 1); end
    total++; if (rsp_q[0] !== a[0] + 3) begin bad++; $display("FAIL b2b_first_dlat got=%0d want=%0d", rsp_q[0], a[0] + 3); end
    total++; if (a[2] !== rsp_q[0] + 1) begin bad++; $display("FAIL b2b_third_accept got=%0d want=%0d", a[2], rsp_q[0] + 1); end
    total++; if (rsp_q[1] !== rsp_q[0] + 3) begin bad++; $display("FAIL b2b_second_dlat got=%0d want=%0d", rsp_q[1], rsp_q[0] + 3); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rsp_d[i] !== v[i]) begin bad++; $display("FAIL b2b_order idx=%0d got=%h want=%h", i, rsp_d[i], v[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int s0, a0, s1, a1, s2, a2; bit ok0, ok1, ok2, okw;
    sel = 2'd1; flush();
    issue(1'b0, 4'h0, 32'h0, 32'h0, s0, a0, ok0);
    issue(1'b0, 4'h0, 32'h4, 32'h0, s1, a1, ok1);
    req = 1'b0; wr = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    flush();
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    total++; if (rsp_q.size() !== 0) begin bad++; $display("FAIL rstmid_dropped got=%0d want=0", rsp_q.size()); end
    issue(1'b0, 4'h0, 32'h8, 32'h0, s2, a2, ok2);
    go_idle(1);
    wait_rsp(1, okw);
    total++; if ((ok0 & ok1 & ok2 & okw) !== 1'b1) begin bad++; $display("FAIL rstmid_timeout got=0 want=1"); end
    total++; if (rsp_d[0] !== 32'hA0A0_0003) begin bad++; $display("FAIL rstmid_ram_kept got=%h want=a0a00003", rsp_d[0]); end
    total++; if (rsp_q[0] !== a2 + 3) begin bad++; $display("FAIL rstmid_dlat got=%0d want=%0d", rsp_q[0], a2 + 3); end
  endtask

  task automatic test_addr_delay();
    int s0, a0, s1, a1, s2, a2; bit ok0, ok1, ok2, okw1, okw2;
    sel = 2'd3; flush();
    go_idle(1);
    issue(1'b1, 4'hF, 32'h500, 32'h5555, s0, a0, ok0);
    issue(1'b0, 4'h0, 32'h500, 32'h0, s1, a1, ok1);
    go_idle(1);
    wait_rsp(2, okw1);
    total++; if (a0 - s0 !== 2) begin bad++; $display("FAIL adly_alat got=%0d want=2", a0 - s0); end
    total++; if (rsp_q[0] !== a0 + 2) begin bad++; $display("FAIL adly_dlat got=%0d want=%0d", rsp_q[0], a0 + 2); end
    total++; if (a1 !== rsp_q[0] + 1) begin bad++; $display("FAIL adly_full_resume got=%0d want=%0d", a1, rsp_q[0] + 1); end
    total++; if (rsp_d[1] !== 32'h5555) begin bad++; $display("FAIL adly_data got=%h want=5555", rsp_d[1]); end
    // Drop req before the handshake: nothing is written and the delay restarts.
    go_idle(2); flush();
    req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h500; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (addr_ok_m !== 1'b0) begin bad++; $display("FAIL adly_early_ok got=%b want=0", addr_ok_m); end
    @(posedge clk); #1;
    go_idle(1);
    issue(1'b0, 4'h0, 32'h500, 32'h0, s2, a2, ok2);
    go_idle(1);
    wait_rsp(1, okw2);
    total++; if ((ok0 & ok1 & ok2 & okw1 & okw2) !== 1'b1) begin bad++; $display("FAIL adly_timeout got=0 want=1"); end
    total++; if (a2 - s2 !== 2) begin bad++; $display("FAIL adly_reload got=%0d want=2", a2 - s2); end
    total++; if (rsp_d[0] !== 32'h5555) begin bad++; $display("FAIL adly_no_write got=%h want=5555", rsp_d[0]); end
  endtask

  task automatic test_random();
    logic [31:0] mref [16];
    logic [31:0] exp_q[$];
    int          acc_l[$];
    bit          hd_l[$];
    int          n, s, a, idx, lat;
    bit          ok, okw, all, iso;
    logic        w;
    logic [3:0]  st;
    logic [31:0] d;
    sel = 2'd2; flush(); go_idle(1);
    n = 0; all = 1'b1;
    for (int i = 0; i < 1016; i++) begin
      if (i < 16) begin
        w = 1'b1; st = 4'hF; idx = i; iso = 1'b0;
      end else begin
        w = 1'($urandom_range(0, 1)); st = 4'($urandom_range(0, 15));
        idx = $urandom_range(0, 15); iso = ($urandom_range(0, 2) == 0);
      end
      d = $urandom;
      if (iso) begin go_idle(1); wait_rsp(n, okw); all &= okw; end
      issue(w, st, 32'h400 + 32'(4 * idx), d, s, a, ok);
      all &= ok;
      if (iso) begin
        lat = a - s;
        total++; if (lat < 0 || lat > 3) begin bad++; $display("FAIL rand_alat op=%0d got=%0d want=0..3", i, lat); end
      end
      if (w) begin
        for (int b = 0; b < 4; b++) if (st[b]) mref[idx][8*b +: 8] = d[8*b +: 8];
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(mref[idx]);
      end
      acc_l.push_back(a);
      hd_l.push_back(iso);
      n++;
    end
    go_idle(1);
    wait_rsp(n, okw);
    all &= okw;
    total++; if (all !== 1'b1) begin bad++; $display("FAIL rand_timeout got=0 want=1"); end
    total++; if (rsp_q.size() !== n) begin bad++; $display("FAIL rand_count got=%0d want=%0d", rsp_q.size(), n); end
    for (int i = 0; i < n && i < rsp_q.size(); i++) begin
      total++; if (rsp_d[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data idx=%0d got=%h want=%h", i, rsp_d[i], exp_q[i]); end
      if (hd_l[i]) begin
        lat = rsp_q[i] - acc_l[i];
        total++; if (lat < 1 || lat > 8) begin bad++; $display("FAIL rand_dlat idx=%0d got=%0d want=1..8", i, lat); end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    sel = 2'd0; resetn = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_strobe();
    test_raw();
    test_back_to_back();
    test_reset_midflight();
    test_addr_delay();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
